// File: rtl/ppu_pkg.sv
// Shared PPU encodings: op codes and scheduler state type.
package ppu_pkg;

    localparam int unsigned OP_SIZE = 2;

    localparam logic [OP_SIZE-1:0] ADD = 2'd0;
    localparam logic [OP_SIZE-1:0] SUB = 2'd1;
    localparam logic [OP_SIZE-1:0] MUL = 2'd2;
    localparam logic [OP_SIZE-1:0] DIV = 2'd3;

    typedef enum logic {
        RUN      = 1'b0,
        DIV_WAIT = 1'b1
    } sched_state_t;

endpackage

// File: rtl/ppu_op_scheduler_rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first requester after the last accepted one.
module rr_arbiter #(
    parameter  int unsigned NREQ = 2,
    localparam int unsigned IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [NREQ-1:0] req_i,
    input  logic            accept_i,
    output logic [NREQ-1:0] grant_o,
    output logic [IDW-1:0]  grant_idx_o
);

    logic [IDW-1:0] ptr_q;
    logic           found_c;
    int unsigned    idx_c;

    // Scan cyclically starting just after the last accepted requester.
    always_comb begin
        grant_o     = '0;
        grant_idx_o = '0;
        found_c     = 1'b0;
        idx_c       = 0;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            idx_c = (32'(ptr_q) + k) % NREQ;
            if (!found_c && req_i[IDW'(idx_c)]) begin
                grant_o[IDW'(idx_c)] = 1'b1;
                grant_idx_o          = IDW'(idx_c);
                found_c              = 1'b1;
            end
        end
    end

    // Pointer moves only on an accepted grant; reset value gives requester 0 top priority.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= IDW'(NREQ - 1);
        end else if (accept_i) begin
            ptr_q <= grant_idx_o;
        end
    end

endmodule

// File: rtl/ppu_op_scheduler.sv
// PPU op scheduler: arbitrates requesters, issues ops to the core, returns tagged results.
module ppu_op_scheduler
    import ppu_pkg::*;
#(
    parameter  int unsigned N        = 16,
    parameter  int unsigned NREQ     = 2,
    parameter  int unsigned TAG_W    = 4,
    parameter  int unsigned PIPE_LAT = 1,
    parameter  int unsigned DIV_LAT  = 4,
    localparam int unsigned IDW      = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req_valid,
    output logic [NREQ-1:0]         req_ready,
    input  logic [NREQ*OP_SIZE-1:0] req_op,
    input  logic [NREQ*N-1:0]       req_a,
    input  logic [NREQ*N-1:0]       req_b,
    input  logic [NREQ*TAG_W-1:0]   req_tag,
    output logic                    core_start,
    output logic [OP_SIZE-1:0]      core_op,
    output logic [N-1:0]            core_in1,
    output logic [N-1:0]            core_in2,
    input  logic [N-1:0]            core_result,
    output logic                    rsp_valid,
    output logic [IDW-1:0]          rsp_id,
    output logic [TAG_W-1:0]        rsp_tag,
    output logic [N-1:0]            rsp_result
);

    localparam int unsigned CNT_W    = $clog2(DIV_LAT + 1);
    localparam int unsigned PIPE_IDX = DIV_LAT - PIPE_LAT;

    typedef struct packed {
        logic             valid;
        logic [IDW-1:0]   id;
        logic [TAG_W-1:0] tag;
    } trk_entry_t;

    if (PIPE_LAT < 1 || DIV_LAT < PIPE_LAT) begin : g_bad_lat
        $error("ppu_op_scheduler: need 1 <= PIPE_LAT <= DIV_LAT");
    end

    sched_state_t       state_q;
    logic [CNT_W-1:0]   div_cnt_q;
    logic               core_start_q;
    logic [OP_SIZE-1:0] core_op_q;
    logic [N-1:0]       core_in1_q;
    logic [N-1:0]       core_in2_q;
    logic [IDW-1:0]     iss_id_q;
    logic [TAG_W-1:0]   iss_tag_q;
    trk_entry_t         trk_q [DIV_LAT];

    logic [NREQ-1:0]    arb_req_c;
    logic [NREQ-1:0]    grant_c;
    logic [IDW-1:0]     grant_idx_c;
    logic               hs_c;
    logic [OP_SIZE-1:0] sel_op_c;
    logic [N-1:0]       sel_a_c;
    logic [N-1:0]       sel_b_c;
    logic [TAG_W-1:0]   sel_tag_c;
    trk_entry_t         new_entry_c;

    // Requests are only visible to the arbiter while accepting and out of reset.
    assign arb_req_c = (rst && state_q == RUN) ? req_valid : '0;
    assign req_ready = grant_c;
    assign hs_c      = |(req_valid & grant_c);

    rr_arbiter #(
        .NREQ (NREQ)
    ) u_arb (
        .clk         (clk),
        .rst_n       (rst),
        .req_i       (arb_req_c),
        .accept_i    (hs_c),
        .grant_o     (grant_c),
        .grant_idx_o (grant_idx_c)
    );

    assign sel_op_c  = req_op[grant_idx_c*OP_SIZE +: OP_SIZE];
    assign sel_a_c   = req_a[grant_idx_c*N +: N];
    assign sel_b_c   = req_b[grant_idx_c*N +: N];
    assign sel_tag_c = req_tag[grant_idx_c*TAG_W +: TAG_W];

    assign new_entry_c = '{valid: 1'b1, id: iss_id_q, tag: iss_tag_q};

    // Scheduler FSM: a DIV handshake blocks acceptance for DIV_LAT cycles.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= RUN;
            div_cnt_q <= '0;
        end else begin
            case (state_q)
                RUN: begin
                    if (hs_c && sel_op_c == DIV) begin
                        state_q   <= DIV_WAIT;
                        div_cnt_q <= CNT_W'(DIV_LAT);
                    end
                end
                DIV_WAIT: begin
                    if (div_cnt_q == CNT_W'(1)) begin
                        state_q   <= RUN;
                        div_cnt_q <= '0;
                    end else begin
                        div_cnt_q <= div_cnt_q - CNT_W'(1);
                    end
                end
                default: begin
                    state_q   <= RUN;
                    div_cnt_q <= '0;
                end
            endcase
        end
    end

    // Issue register: payload captured on handshake, held otherwise.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            core_start_q <= 1'b0;
            core_op_q    <= ADD;
            core_in1_q   <= '0;
            core_in2_q   <= '0;
            iss_id_q     <= '0;
            iss_tag_q    <= '0;
        end else begin
            core_start_q <= hs_c;
            if (hs_c) begin
                core_op_q  <= sel_op_c;
                core_in1_q <= sel_a_c;
                core_in2_q <= sel_b_c;
                iss_id_q   <= grant_idx_c;
                iss_tag_q  <= sel_tag_c;
            end
        end
    end

    // Tracking shift register: entry insertion point sets the response latency.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned k = 0; k < DIV_LAT; k++) begin
                trk_q[k] <= '0;
            end
        end else begin
            trk_q[0] <= '0;
            for (int unsigned k = 1; k < DIV_LAT; k++) begin
                trk_q[k] <= trk_q[k-1];
            end
            if (core_start_q) begin
                if (core_op_q == DIV) begin
                    trk_q[0] <= new_entry_c;
                end else begin
                    trk_q[PIPE_IDX] <= new_entry_c;
                end
            end
        end
    end

    if (PIPE_IDX > 0) begin : g_collision_chk
        // A pipelined entry must land on an empty stage.
        a_no_collision: assert property (@(posedge clk) disable iff (!rst)
            (core_start_q && core_op_q != DIV) |-> !trk_q[PIPE_IDX-1].valid);
    end

    assign core_start = core_start_q;
    assign core_op    = core_op_q;
    assign core_in1   = core_in1_q;
    assign core_in2   = core_in2_q;
    assign rsp_valid  = trk_q[DIV_LAT-1].valid;
    assign rsp_id     = trk_q[DIV_LAT-1].id;
    assign rsp_tag    = trk_q[DIV_LAT-1].tag;
    assign rsp_result = core_result;

endmodule

// File: tb/tb_ppu_op_scheduler.sv
// Randomized bench for ppu_op_scheduler against a cycle-schedule reference model.
module tb_ppu_op_scheduler;
    import ppu_pkg::*;

    localparam int unsigned N        = 16;
    localparam int unsigned NREQ     = 2;
    localparam int unsigned TAG_W    = 4;
    localparam int unsigned PIPE_LAT = 1;
    localparam int unsigned DIV_LAT  = 4;
    localparam int unsigned IDW      = 1;

    logic                    clk = 1'b0;
    logic                    rst;
    logic [NREQ-1:0]         req_valid;
    logic [NREQ-1:0]         req_ready;
    logic [NREQ*OP_SIZE-1:0] req_op;
    logic [NREQ*N-1:0]       req_a;
    logic [NREQ*N-1:0]       req_b;
    logic [NREQ*TAG_W-1:0]   req_tag;
    logic                    core_start;
    logic [OP_SIZE-1:0]      core_op;
    logic [N-1:0]            core_in1;
    logic [N-1:0]            core_in2;
    logic [N-1:0]            core_result;
    logic                    rsp_valid;
    logic [IDW-1:0]          rsp_id;
    logic [TAG_W-1:0]        rsp_tag;
    logic [N-1:0]            rsp_result;

    always #5 clk = ~clk;

    ppu_op_scheduler #(
        .N(N), .NREQ(NREQ), .TAG_W(TAG_W), .PIPE_LAT(PIPE_LAT), .DIV_LAT(DIV_LAT)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_a(req_a), .req_b(req_b), .req_tag(req_tag),
        .core_start(core_start), .core_op(core_op),
        .core_in1(core_in1), .core_in2(core_in2), .core_result(core_result),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_tag(rsp_tag), .rsp_result(rsp_result)
    );

    // Per-requester stimulus, packed onto the flat buses.
    bit               r_v   [NREQ];
    logic [1:0]       r_op  [NREQ];
    logic [N-1:0]     r_a   [NREQ];
    logic [N-1:0]     r_b   [NREQ];
    logic [TAG_W-1:0] r_tag [NREQ];

    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            req_valid[i]                  = r_v[i];
            req_op[i*OP_SIZE +: OP_SIZE]  = r_op[i];
            req_a[i*N +: N]               = r_a[i];
            req_b[i*N +: N]               = r_b[i];
            req_tag[i*TAG_W +: TAG_W]     = r_tag[i];
        end
    end

    typedef struct {
        int               cyc;
        int               id;
        logic [TAG_W-1:0] tag;
    } rsp_t;

    int               n_tests = 0;
    int               n_fail  = 0;
    int               cyc;
    int               blk_end;
    int               last;
    int               mode;
    bit               acc [NREQ];
    bit               div_hs_seen;
    bit               exp_start;
    logic [1:0]       exp_op;
    logic [N-1:0]     exp_in1;
    logic [N-1:0]     exp_in2;
    logic [TAG_W-1:0] tag_ctr;
    rsp_t             rq [$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    task automatic model_reset();
        blk_end   = 0;
        last      = NREQ - 1;
        rq.delete();
        exp_start = 1'b0;
        exp_op    = ADD;
        exp_in1   = '0;
        exp_in2   = '0;
        for (int i = 0; i < NREQ; i++) acc[i] = 1'b1;
    endtask

    // New payload only for idle or just-accepted requesters; pending ones hold.
    task automatic update_stim();
        for (int i = 0; i < NREQ; i++) begin
            if (!r_v[i] || acc[i]) begin
                acc[i]   = 1'b0;
                r_a[i]   = N'($urandom);
                r_b[i]   = N'($urandom);
                r_tag[i] = TAG_W'($urandom);
                case (mode)
                    0: begin
                        r_v[i]  = (i == 0);
                        r_op[i] = ADD;
                        if (i == 0) begin
                            r_tag[i] = tag_ctr;
                            tag_ctr  = tag_ctr + 4'd1;
                        end
                    end
                    1: begin
                        r_v[i]  = 1'b1;
                        r_op[i] = MUL;
                    end
                    2: begin
                        r_v[i]  = ($urandom_range(0, 9) < 7);
                        r_op[i] = 2'($urandom_range(0, 3));
                    end
                    3: begin
                        r_v[i]  = 1'b1;
                        r_op[i] = (i == 0) ? DIV : MUL;
                    end
                    default: begin
                        r_v[i]  = (i == 0);
                        r_op[i] = DIV;
                    end
                endcase
            end
        end
        core_result = N'($urandom);
    endtask

    // Compare one cycle's outputs, then advance the model by that cycle's handshake.
    task automatic step();
        int g;
        int lat;
        logic [NREQ-1:0] exp_rdy;
        @(negedge clk);
        check_eq("core_start", 32'(core_start), 32'(exp_start));
        check_eq("core_op", 32'(core_op), 32'(exp_op));
        check_eq("core_in1", 32'(core_in1), 32'(exp_in1));
        check_eq("core_in2", 32'(core_in2), 32'(exp_in2));
        if (rq.size() > 0 && rq[0].cyc == cyc) begin
            check_eq("rsp_valid", 32'(rsp_valid), 32'd1);
            check_eq("rsp_id", 32'(rsp_id), 32'(rq[0].id));
            check_eq("rsp_tag", 32'(rsp_tag), 32'(rq[0].tag));
            check_eq("rsp_result", 32'(rsp_result), 32'(core_result));
            void'(rq.pop_front());
        end else begin
            check_eq("rsp_valid_idle", 32'(rsp_valid), 32'd0);
        end
        g = -1;
        if (cyc >= blk_end) begin
            for (int k = 1; k <= NREQ; k++) begin
                int idx;
                idx = (last + k) % NREQ;
                if (g < 0 && r_v[idx]) g = idx;
            end
        end
        exp_rdy = '0;
        if (g >= 0) exp_rdy[g] = 1'b1;
        check_eq("req_ready", 32'(req_ready), 32'(exp_rdy));
        if (g >= 0) begin
            acc[g]    = 1'b1;
            last      = g;
            exp_start = 1'b1;
            exp_op    = r_op[g];
            exp_in1   = r_a[g];
            exp_in2   = r_b[g];
            lat       = (r_op[g] == DIV) ? DIV_LAT : PIPE_LAT;
            rq.push_back('{cyc + 1 + lat, g, r_tag[g]});
            if (r_op[g] == DIV) begin
                blk_end     = cyc + DIV_LAT + 1;
                div_hs_seen = 1'b1;
            end
        end else begin
            exp_start = 1'b0;
        end
    endtask

    task automatic run_cycles(input int n);
        for (int c = 0; c < n; c++) begin
            update_stim();
            step();
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        cyc     = 0;
        tag_ctr = 4'd1;
        mode    = 1;
        rst     = 1'b0;
        core_result = '0;
        for (int i = 0; i < NREQ; i++) begin
            r_v[i]   = 1'b1;
            r_op[i]  = MUL;
            r_a[i]   = N'($urandom);
            r_b[i]   = N'($urandom);
            r_tag[i] = TAG_W'(i + 5);
        end
        model_reset();

        // Held in reset with both requesters valid.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_req_ready", 32'(req_ready), 32'd0);
        check_eq("rst_core_start", 32'(core_start), 32'd0);
        check_eq("rst_core_op", 32'(core_op), 32'(ADD));
        check_eq("rst_core_in1", 32'(core_in1), 32'd0);
        check_eq("rst_core_in2", 32'(core_in2), 32'd0);
        check_eq("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check_eq("rst_rsp_id", 32'(rsp_id), 32'd0);
        check_eq("rst_rsp_tag", 32'(rsp_tag), 32'd0);

        @(posedge clk);
        #1;
        rst = 1'b1;
        for (int i = 0; i < NREQ; i++) acc[i] = 1'b0;

        mode = 1;  run_cycles(12);    // round-robin MULs
        mode = 0;  run_cycles(12);    // back-to-back ADDs from requester 0
        mode = 3;  run_cycles(30);    // DIV blocking with a queued MUL
        mode = 2;  run_cycles(400);   // random mix

        // Reset two cycles after a DIV handshake discards that DIV.
        mode = 4;
        div_hs_seen = 1'b0;
        for (int c = 0; c < 40 && !div_hs_seen; c++) run_cycles(1);
        check_eq("div_handshake_seen", 32'(div_hs_seen), 32'd1);
        run_cycles(1);
        rst = 1'b0;
        @(negedge clk);
        check_eq("midrst_req_ready", 32'(req_ready), 32'd0);
        check_eq("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
        check_eq("midrst_core_start", 32'(core_start), 32'd0);
        @(posedge clk);
        #1;
        cyc++;
        rst = 1'b1;
        model_reset();
        mode = 0;
        run_cycles(20);
        mode = 2;
        run_cycles(100);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
